// File: rtl/imem_loader_if.sv
// imem_loader_if
//   Groups the word stream (upstream producer -> loader) and the byte-wide
//   instruction-memory write port (loader -> memory) into one bundle.
//
//   Signals
//     word_valid  producer has a word available
//     word_data   32-bit instruction word
//     word_last   marks the final word of a program
//     word_ready  loader accepts the word this cycle
//     mem_we      byte write strobe to instruction memory
//     mem_addr    byte address (ADDR_W bits)
//     mem_wdata   byte data
//
//   Modports
//     master  the environment side: drives the word stream, observes the
//             handshake and the memory port
//     slave   the loader side: consumes the word stream, drives the memory port
interface imem_loader_if #(
    parameter int ADDR_W = 8
);
    logic              word_valid;
    logic [31:0]       word_data;
    logic              word_last;
    logic              word_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;

    modport master (
        output word_valid, word_data, word_last,
        input  word_ready, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  word_valid, word_data, word_last,
        output word_ready, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/imem_loader.sv
// imem_loader
//   Accepts a stream of 32-bit instruction words and writes each one into a
//   byte-wide instruction memory as four little-endian byte writes, starting
//   at byte address 0. While loading, the downstream processor is held in
//   reset; once the program is complete (word_last) or capacity is reached,
//   the processor is released and done is raised.
//
//   Parameters
//     ADDR_W     instruction-memory byte-address width
//     MAX_WORDS  load capacity in 32-bit words (MAX_WORDS*4 <= 2**ADDR_W)
//
//   Ports
//     clk         rising-edge clock
//     reset       asynchronous, active-low reset
//     start       pulse that begins a load (honoured in IDLE and DONE only)
//     bus         imem_loader_if.slave: word stream in, memory write port out
//     cpu_reset   active-high processor reset hold (low only in DONE)
//     done        load finished
//     overflow    capacity reached without seeing word_last
//     word_count  words accepted in the current load
//     checksum    modulo-2^32 sum of accepted words
//
//   Build option
//     IMEM_LOADER_CHECKSUM_EN  when defined, checksum accumulates every
//                              accepted word; otherwise it is tied to 0.
module imem_loader #(
    parameter int ADDR_W    = 8,
    parameter int MAX_WORDS = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    imem_loader_if.slave bus,
    output logic         cpu_reset,
    output logic         done,
    output logic         overflow,
    output logic [6:0]   word_count,
    output logic [31:0]  checksum
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_WORD,
        WRITE,
        DONE
    } state_t;

    localparam logic [6:0]        MAX_CNT   = 7'(MAX_WORDS);
    localparam logic [ADDR_W-1:0] WORD_STEP = ADDR_W'(4);

    state_t            state_q, state_d;
    logic              last_q, last_d;
    logic [1:0]        byte_q, byte_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        wdata_q, wdata_d;
    logic [6:0]        count_q, count_d;
    logic              ovf_q, ovf_d;
    // Upper three bytes of the captured word; byte 0 goes straight to
    // mem_wdata on the acceptance edge so it never needs storing.
    logic [23:0]       hi_q;

    logic              accept;
    logic              restart;

    assign accept  = (state_q == WAIT_WORD) && bus.word_valid;
    assign restart = ((state_q == IDLE) || (state_q == DONE)) && start;

    // ---- next-state / datapath decode ----
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        byte_d  = byte_q;
        base_d  = base_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        count_d = count_q;
        ovf_d   = ovf_q;

        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = WAIT_WORD;
                    count_d = '0;
                    base_d  = '0;
                    ovf_d   = 1'b0;
                end
            end
            WAIT_WORD: begin
                if (bus.word_valid) begin
                    state_d = WRITE;
                    last_d  = bus.word_last;
                    count_d = count_q + 7'd1;
                    // First byte is presented together with mem_we on the
                    // very next cycle, so address/data are loaded here.
                    addr_d  = base_q;
                    wdata_d = bus.word_data[7:0];
                    base_d  = base_q + WORD_STEP;
                    byte_d  = 2'd0;
                end
            end
            WRITE: begin
                if (byte_q == 2'd3) begin
                    // Address/data are left untouched so they hold the last
                    // written byte while mem_we is low.
                    if (last_q || (count_q == MAX_CNT)) begin
                        state_d = DONE;
                        ovf_d   = !last_q && (count_q == MAX_CNT);
                    end else begin
                        state_d = WAIT_WORD;
                    end
                end else begin
                    byte_d = byte_q + 2'd1;
                    addr_d = addr_q + ADDR_W'(1);
                    case (byte_q)
                        2'd0:    wdata_d = hi_q[7:0];
                        2'd1:    wdata_d = hi_q[15:8];
                        default: wdata_d = hi_q[23:16];
                    endcase
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // ---- state register ----
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            last_q  <= 1'b0;
            byte_q  <= 2'd0;
            base_q  <= '0;
            addr_q  <= '0;
            wdata_q <= 8'd0;
            count_q <= 7'd0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            byte_q  <= byte_d;
            base_q  <= base_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    // Pure data holding register: only ever read after a capture, so it
    // carries no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            hi_q <= bus.word_data[31:8];
        end
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [31:0] sum_q, sum_d;

    always_comb begin
        sum_d = sum_q;
        if (restart) begin
            sum_d = 32'd0;
        end else if (accept) begin
            sum_d = sum_q + bus.word_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sum_q <= 32'd0;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign checksum = sum_q;
`else
    assign checksum = 32'd0;
`endif

    // All handshake and status outputs decode directly from the state so an
    // asynchronous reset takes effect on them immediately.
    assign bus.word_ready = (state_q == WAIT_WORD);
    assign bus.mem_we     = (state_q == WRITE);
    assign bus.mem_addr   = addr_q;
    assign bus.mem_wdata  = wdata_q;
    assign cpu_reset      = (state_q != DONE);
    assign done           = (state_q == DONE);
    assign overflow       = ovf_q;
    assign word_count     = count_q;

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader
//   Scoreboard bench for imem_loader (ADDR_W=8, MAX_WORDS=4). Each load
//   pushes the full expected byte-write sequence computed from the program;
//   an independent monitor pops and compares on every mem_we cycle.
module tb_imem_loader;

    localparam int AW = 8;
    localparam int MW = 4;
`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam bit CK = 1'b1;
`else
    localparam bit CK = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        start;
    logic        cpu_reset;
    logic        done;
    logic        overflow;
    logic [6:0]  word_count;
    logic [31:0] checksum;

    imem_loader_if #(.ADDR_W(AW)) bus ();

    imem_loader #(.ADDR_W(AW), .MAX_WORDS(MW)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .bus        (bus),
        .cpu_reset  (cpu_reset),
        .done       (done),
        .overflow   (overflow),
        .word_count (word_count),
        .checksum   (checksum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          total = 0;
    int          bad   = 0;
    logic [15:0] sb[$];          // {addr, byte}
    logic [31:0] prog[$];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: byte writes against the scoreboard, 4-cycle strobe runs,
    // and address/data holding while idle.
    int          run = 0;
    logic [AW-1:0] prev_addr = '0;
    logic [7:0]  prev_data = '0;

    always @(negedge clk) begin
        logic [15:0] e;
        if (!reset) begin
            run = 0;
            prev_addr = '0;
            prev_data = '0;
        end else if (bus.mem_we) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_we: got addr %h data %h expected no write", bus.mem_addr, bus.mem_wdata);
            end else begin
                e = sb.pop_front();
                check("wr_addr", 32'(bus.mem_addr), 32'(e[15:8]));
                check("wr_data", 32'(bus.mem_wdata), 32'(e[7:0]));
            end
            run++;
            prev_addr = bus.mem_addr;
            prev_data = bus.mem_wdata;
        end else begin
            if (run != 0) begin
                check("we_run_len", 32'(run), 32'd4);
                run = 0;
            end
            check("hold_addr", 32'(bus.mem_addr), 32'(prev_addr));
            check("hold_data", 32'(bus.mem_wdata), 32'(prev_data));
        end
    end

    // One complete load of prog[0..n-1]. with_last=0 never marks a word last.
    task automatic run_load(input int n, input bit cont, input bit with_last);
        int          acc_exp;
        bit          last_in;
        logic [31:0] sum;
        logic [31:0] w;
        int          idx;
        int          cyc;
        int          last_acc;

        acc_exp = (n < MW) ? n : MW;
        last_in = with_last && (n <= MW);
        sum = 32'd0;
        for (int i = 0; i < acc_exp; i++) begin
            w = prog[i];
            sum += w;
            for (int k = 0; k < 4; k++) sb.push_back({8'(4 * i + k), w[8 * k +: 8]});
        end

        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("start_cpu_reset", 32'(cpu_reset), 32'd1);
        check("start_done", 32'(done), 32'd0);
        check("start_count", 32'(word_count), 32'd0);
        check("start_checksum", checksum, 32'd0);
        check("start_overflow", 32'(overflow), 32'd0);
        check("start_ready", 32'(bus.word_ready), 32'd1);

        idx = 0;
        cyc = 0;
        last_acc = 0;
        while (!done && cyc < 500) begin
            if (!cont) start = ($urandom_range(0, 5) == 0);
            if (idx < n) begin
                bus.word_valid = cont ? 1'b1 : ($urandom_range(0, 2) != 0);
                bus.word_data  = prog[idx];
                bus.word_last  = with_last && (idx == n - 1);
            end else begin
                bus.word_valid = 1'b0;
            end
            if (bus.word_valid && bus.word_ready) begin
                if (cont && idx > 0) check("ready_period", 32'(cyc - last_acc), 32'd5);
                last_acc = cyc;
                idx++;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        bus.word_valid = 1'b0;
        bus.word_last = 1'b0;

        if (!done) begin
            total++;
            bad++;
            $display("FAIL load_timeout: got done=%0d expected 1 within 500 cycles", done);
        end
        check("accepted_words", 32'(idx), 32'(acc_exp));
        check("done", 32'(done), 32'd1);
        check("done_cpu_reset", 32'(cpu_reset), 32'd0);
        check("done_ready", 32'(bus.word_ready), 32'd0);
        check("word_count", 32'(word_count), 32'(acc_exp));
        check("overflow", 32'(overflow), last_in ? 32'd0 : 32'd1);
        check("checksum", checksum, CK ? sum : 32'd0);
        check("sb_empty", 32'(sb.size()), 32'd0);
        sb.delete();
    endtask

    initial begin
        logic [31:0] w;
        int          n;
        int          t;

        reset = 1'b0;
        start = 1'b0;
        bus.word_valid = 1'b0;
        bus.word_data  = 32'd0;
        bus.word_last  = 1'b0;

        #3;
        check("rst_ready", 32'(bus.word_ready), 32'd0);
        check("rst_we", 32'(bus.mem_we), 32'd0);
        check("rst_addr", 32'(bus.mem_addr), 32'd0);
        check("rst_wdata", 32'(bus.mem_wdata), 32'd0);
        check("rst_cpu_reset", 32'(cpu_reset), 32'd1);
        check("rst_done", 32'(done), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_count", 32'(word_count), 32'd0);
        check("rst_checksum", checksum, 32'd0);

        repeat (2) @(negedge clk);
        reset = 1'b1;

        // IDLE ignores offered words until start.
        bus.word_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("idle_ready", 32'(bus.word_ready), 32'd0);
        end
        bus.word_valid = 1'b0;

        // Two-word program: bytes 0A,00,00,01,05,00,00,00.
        prog = '{32'h0100000A, 32'h00000005};
        run_load(2, 1'b0, 1'b1);

        // Back-to-back words: one ready cycle per five.
        prog = '{$urandom, $urandom, $urandom};
        run_load(3, 1'b1, 1'b1);

        // Capacity: five unterminated words, only four taken.
        prog = '{$urandom, $urandom, $urandom, $urandom, $urandom};
        run_load(5, 1'b0, 1'b0);

        // Checksum wrap-around.
        prog = '{32'hFFFFFFFF, 32'h00000002};
        run_load(2, 1'b0, 1'b1);

        // Random programs, including exact-capacity and over-capacity cases.
        for (int it = 0; it < 10; it++) begin
            n = $urandom_range(1, 6);
            prog.delete();
            for (int i = 0; i < n; i++) prog.push_back($urandom);
            run_load(n, ($urandom_range(0, 3) == 0), (n < MW) ? 1'b1 : ($urandom_range(0, 1) == 1));
        end

        // Reset while the second byte of a word is being written.
        w = $urandom;
        for (int k = 0; k < 4; k++) sb.push_back({8'(k), w[8 * k +: 8]});
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        bus.word_valid = 1'b1;
        bus.word_data  = w;
        bus.word_last  = 1'b1;
        t = 0;
        while (!bus.mem_we && t < 20) begin
            @(negedge clk);
            bus.word_valid = !bus.word_ready;
            t++;
        end
        bus.word_valid = 1'b0;
        if (!bus.mem_we) begin
            total++;
            bad++;
            $display("FAIL abort_wait: got mem_we=%0d expected 1 within 20 cycles", bus.mem_we);
        end
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("abort_we", 32'(bus.mem_we), 32'd0);
        check("abort_ready", 32'(bus.word_ready), 32'd0);
        check("abort_cpu_reset", 32'(cpu_reset), 32'd1);
        check("abort_done", 32'(done), 32'd0);
        check("abort_count", 32'(word_count), 32'd0);
        check("abort_checksum", checksum, 32'd0);
        check("abort_addr", 32'(bus.mem_addr), 32'd0);
        check("abort_wdata", 32'(bus.mem_wdata), 32'd0);
        sb.delete();
        repeat (3) begin
            @(negedge clk);
            check("abort_we_held", 32'(bus.mem_we), 32'd0);
        end
        reset = 1'b1;
        bus.word_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("post_abort_ready", 32'(bus.word_ready), 32'd0);
            check("post_abort_cpu_reset", 32'(cpu_reset), 32'd1);
        end
        bus.word_valid = 1'b0;

        // Fresh load after the abort starts again at address 0.
        prog = '{$urandom, $urandom};
        run_load(2, 1'b0, 1'b1);

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
- REQ-001 SHALL provide parameter ADDR_W, default 8, meaning instruction-memory byte-address width.
- REQ-002 SHALL provide parameter MAX_WORDS, default 64, meaning load capacity in 32-bit words (MAX_WORDS*4 <= 2**ADDR_W).
- REQ-003 SHALL have port: clk  input  1  rising-edge clock.
- REQ-004 SHALL have port: reset  input  1  asynchronous, active-low reset.
- REQ-005 SHALL have port: start  input  1  pulse that begins a load from byte address 0.
- REQ-006 SHALL have port: word_valid  input  1  upstream word available.
- REQ-007 SHALL have port: word_data  input  32  instruction word.
- REQ-008 SHALL have port: word_last  input  1  marks final word of a program.
- REQ-009 SHALL have port: word_ready  output  1  loader accepts word this cycle.
- REQ-010 SHALL have port: mem_we  output  1  byte write strobe to instruction memory.
- REQ-011 SHALL have port: mem_addr  output  ADDR_W  byte address.
- REQ-012 SHALL have port: mem_wdata  output  8  byte data.
- REQ-013 SHALL have port: cpu_reset  output  1  active-high hold for downstream processor reset input.
- REQ-014 SHALL have port: done  output  1  load finished.
- REQ-015 SHALL have port: overflow  output  1  capacity reached without word_last.
- REQ-016 SHALL have port: word_count  output  7  words accepted in current load.
- REQ-017 SHALL have port: checksum  output  32  modulo-2^32 sum of accepted words.

Function
- REQ-018 SHALL implement states IDLE, WAIT_WORD, WRITE, DONE.
- REQ-019 IDLE SHALL go to WAIT_WORD on start=1; start is ignored in WAIT_WORD and WRITE.
- REQ-020 word_ready SHALL be 1 only in WAIT_WORD; a word SHALL be accepted on the edge where word_valid=1 and word_ready=1, capturing word_data and word_last.
- REQ-021 After acceptance at cycle N, WRITE SHALL assert mem_we for exactly cycles N+1..N+4, writing bytes [7:0],[15:8],[23:16],[31:24] to addresses base, base+1, base+2, base+3 (little-endian).
- REQ-022 base SHALL start at 0 and increase by 4 per word; mem_addr SHALL never wrap.
- REQ-023 After the fourth byte, the FSM SHALL go to DONE if the captured word_last=1 or word_count=MAX_WORDS, else to WAIT_WORD.
- REQ-024 overflow SHALL set on entering DONE with word_count=MAX_WORDS and captured word_last=0; cleared on next start.
- REQ-025 word_count SHALL increment on each acceptance and be zeroed on start in IDLE or DONE.
- REQ-026 cpu_reset SHALL be 1 in IDLE, WAIT_WORD, WRITE and 0 only in DONE.
- REQ-027 done SHALL be 1 only in DONE; start=1 in DONE SHALL return to WAIT_WORD, zero word_count, base and checksum, and assert cpu_reset next cycle.
- REQ-028 When mem_we=0, mem_addr and mem_wdata SHALL hold their last values.

Reset
- REQ-029 reset=0 SHALL immediately force IDLE, word_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_reset=1, done=0, overflow=0, word_count=0, checksum=0.
- REQ-030 reset asserted mid-WRITE SHALL abort the remaining byte writes with no further mem_we.

Configuration
- REQ-031 With IMEM_LOADER_CHECKSUM_EN defined, checksum SHALL add each accepted word on its acceptance edge; without it, checksum SHALL be constant 0 with no adder.

Verification
- REQ-032 Load 0x0100000A(last=0), 0x00000005(last=1) -> bytes 0A,00,00,01,05,00,00,00 at addr 0..7; done=1; cpu_reset=0; word_count=2.
- REQ-033 word_valid held 1 continuously -> word_ready high 1 cycle per 5; mem_we high exactly 4 cycles per word.
- REQ-034 MAX_WORDS=4, feed 5 words never last -> DONE after 16 writes, overflow=1, fifth word not accepted.
- REQ-035 reset=0 during second byte of a word -> mem_we=0 same cycle, state IDLE, cpu_reset=1, all counters 0.
- REQ-036 With IMEM_LOADER_CHECKSUM_EN, load 0xFFFFFFFF then 0x00000002(last) -> checksum=0x00000001; restart via start -> checksum=0.
